// File: rtl/lsu_byte_master.sv
// Load/store initiator: performs one word/half/byte request as a sequence of single-byte,
// little-endian memory cycles and returns an extended load result or store completion.
module lsu_byte_master #(
  parameter int unsigned ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_write_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [2:0]            req_type_i,
  input  logic [31:0]           req_wdata_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [31:0]           resp_rdata_o,
  output logic                  resp_err_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_we_o,
  output logic [7:0]            mem_wdata_o,
  input  logic [7:0]            mem_rdata_i
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e                  state_q, state_d;
  logic                    write_q, write_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [2:0]              type_q, type_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [1:0]              cnt_q, cnt_d;
  logic [31:0]             data_q, data_d;
  logic [31:0]             resp_rdata_q, resp_rdata_d;
  logic                    resp_err_q, resp_err_d;

  logic                    type_ok;
  logic [1:0]              last_cnt;
  logic                    last_byte;
  logic [31:0]             assembled;
  logic [31:0]             extended;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= StIdle;
      write_q      <= 1'b0;
      addr_q       <= '0;
      type_q       <= 3'd0;
      wdata_q      <= 32'd0;
      cnt_q        <= 2'd0;
      data_q       <= 32'd0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      type_q       <= type_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      data_q       <= data_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign type_ok   = (req_type_i <= 3'd4);
  assign last_byte = (cnt_q == last_cnt);

  always_comb begin
    last_cnt = 2'd0;
    unique case (type_q)
      3'd0:       last_cnt = 2'd3;
      3'd1, 3'd2: last_cnt = 2'd1;
      default:    last_cnt = 2'd0;
    endcase
  end

  // Result must include the byte being read this cycle, not just the captured ones.
  always_comb begin
    assembled = data_q;
    assembled[{cnt_q, 3'b000} +: 8] = mem_rdata_i;
    extended = assembled;
    unique case (type_q)
      3'd1:    extended = {{16{assembled[15]}}, assembled[15:0]};
      3'd2:    extended = {16'd0, assembled[15:0]};
      3'd3:    extended = {{24{assembled[7]}}, assembled[7:0]};
      3'd4:    extended = {24'd0, assembled[7:0]};
      default: extended = assembled;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (req_valid_i) state_d = type_ok ? StAccess : StResp;
      StAccess: if (last_byte) state_d = StResp;
      StResp:   if (resp_ready_i) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    write_d      = write_q;
    addr_d       = addr_q;
    type_d       = type_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    data_d       = data_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          write_d      = req_write_i;
          addr_d       = req_addr_i;
          type_d       = req_type_i;
          wdata_d      = req_wdata_i;
          cnt_d        = 2'd0;
          data_d       = 32'd0;
          resp_rdata_d = 32'd0;
          resp_err_d   = !type_ok;
        end
      end
      StAccess: begin
        cnt_d = cnt_q + 2'd1;
        if (!write_q) data_d = assembled;
        if (last_byte) begin
          cnt_d        = 2'd0;
          resp_rdata_d = write_q ? 32'd0 : extended;
        end
      end
      StResp: begin
        if (resp_ready_i) begin
          resp_rdata_d = 32'd0;
          resp_err_d   = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    req_ready_o  = (state_q == StIdle);
    resp_valid_o = (state_q == StResp);
    resp_rdata_o = resp_rdata_q;
    resp_err_o   = resp_err_q;
    mem_we_o     = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = 8'd0;
    if (state_q == StAccess) begin
      mem_addr_o = addr_q + ADDR_WIDTH'(cnt_q);
      if (write_q) begin
        mem_we_o    = 1'b1;
        mem_wdata_o = wdata_q[{cnt_q, 3'b000} +: 8];
      end
    end
  end

endmodule
